// File: rtl/seq_shift_left_8.sv
// Multi-cycle logical left shifter, one bit per clock; done pulses b+1 edges after accept (1 edge for b==0 or b>=WIDTH).
// No backpressure: start is sampled only in IDLE and ignored while busy; the result holds until the next accepted start.
module seq_shift_left_8 #(
   parameter int WIDTH   = 8,
   parameter int SHAMT_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [SHAMT_W-1:0] b,
   output logic [WIDTH-1:0]   out,
   output logic               ovf,
   output logic               busy,
   output logic               done
);

   localparam logic [SHAMT_W-1:0] WIDTH_SH = SHAMT_W'(WIDTH);
   localparam logic [SHAMT_W-1:0] ONE_SH   = SHAMT_W'(1);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t             state, state_nxt;
   logic [SHAMT_W-1:0] cnt, cnt_nxt;
   logic [WIDTH-1:0]   out_nxt;
   logic               ovf_nxt;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         out   <= '0;
         ovf   <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         out   <= out_nxt;
         ovf   <= ovf_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      out_nxt   = out;
      ovf_nxt   = ovf;
      case (state)
         IDLE: begin
            if (start) begin
               if (b == '0) begin
                  out_nxt   = a;
                  ovf_nxt   = 1'b0;
                  state_nxt = DONE;
               end else if (b >= WIDTH_SH) begin
                  // Every bit leaves the word, so no need to iterate.
                  out_nxt   = '0;
                  ovf_nxt   = |a;
                  state_nxt = DONE;
               end else begin
                  out_nxt   = a;
                  ovf_nxt   = 1'b0;
                  cnt_nxt   = b;
                  state_nxt = SHIFT;
               end
            end
         end
         SHIFT: begin
            out_nxt = {out[WIDTH-2:0], 1'b0};
            ovf_nxt = ovf | out[WIDTH-1];
            cnt_nxt = cnt - ONE_SH;
            if (cnt == ONE_SH) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   assign busy = (state != IDLE);
   assign done = (state == DONE);

endmodule

// File: tb/tb_seq_shift_left_8.sv
// Directed bench for seq_shift_left_8: reset, fast paths, iterative shifts, start during busy, mid-op reset, sweep.
module tb_seq_shift_left_8;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [7:0] a;
   logic [7:0] b;
   logic [7:0] out;
   logic       ovf;
   logic       busy;
   logic       done;

   int total_cnt = 0;
   int pass_cnt  = 0;
   int fail_cnt  = 0;

   seq_shift_left_8 #(.WIDTH(8), .SHAMT_W(8)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .out   (out),
      .ovf   (ovf),
      .busy  (busy),
      .done  (done)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input int obs, input int exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Pulses start for one edge, scrambles a/b afterwards, then waits (bounded) for done.
   task automatic run_op(input logic [7:0] ta, input logic [7:0] tb,
                         output int lat, output int bsy);
      a     = ta;
      b     = tb;
      start = 1'b1;
      step();
      start = 1'b0;
      a     = 8'($urandom);
      b     = 8'($urandom);
      lat   = 1;
      bsy   = int'(busy);
      while (!done && lat < 40) begin
         step();
         lat++;
         bsy += int'(busy);
      end
   endtask

   initial begin
      int lat, bsy, exp_lat, cyc;
      logic [7:0] exp_out, ta;
      logic       exp_ovf;
      logic [7:0] pats [4];

      rst = 1'b1; start = 1'b0; a = 8'h00; b = 8'h00;
      step();
      step();
      check("reset_out",  int'(out),  0);
      check("reset_ovf",  int'(ovf),  0);
      check("reset_busy", int'(busy), 0);
      check("reset_done", int'(done), 0);
      rst = 1'b0;
      step();
      check("idle_busy", int'(busy), 0);

      // 0x96 << 3
      run_op(8'h96, 8'd3, lat, bsy);
      check("t1_lat",  lat,        4);
      check("t1_busy", bsy,        4);
      check("t1_out",  int'(out),  8'hB0);
      check("t1_ovf",  int'(ovf),  1);
      step();
      check("t1_done_pulse", int'(done), 0);
      check("t1_idle",       int'(busy), 0);
      check("t1_hold_out",   int'(out),  8'hB0);
      check("t1_hold_ovf",   int'(ovf),  1);

      run_op(8'h5A, 8'd0, lat, bsy);
      check("t2_lat", lat,       1);
      check("t2_out", int'(out), 8'h5A);
      check("t2_ovf", int'(ovf), 0);
      step();

      run_op(8'h01, 8'd9, lat, bsy);
      check("t3a_lat", lat,       1);
      check("t3a_out", int'(out), 8'h00);
      check("t3a_ovf", int'(ovf), 1);
      step();
      run_op(8'h00, 8'd8, lat, bsy);
      check("t3b_lat", lat,       1);
      check("t3b_out", int'(out), 8'h00);
      check("t3b_ovf", int'(ovf), 0);
      step();

      // start held high through SHIFT and DONE
      a = 8'h0F; b = 8'd4; start = 1'b1;
      step();
      a = 8'hFF; b = 8'd1;
      lat = 1;
      while (!done && lat < 40) begin
         step();
         lat++;
      end
      check("t4a_lat", lat,       5);
      check("t4a_out", int'(out), 8'hF0);
      check("t4a_ovf", int'(ovf), 0);
      cyc = 0;
      do begin
         step();
         cyc++;
      end while (!done && cyc < 40);
      check("t4b_gap", cyc,       3);
      check("t4b_out", int'(out), 8'hFE);
      check("t4b_ovf", int'(ovf), 1);
      start = 1'b0;
      step();
      step();
      step();
      check("t4_no_third_op", int'(busy), 0);
      check("t4_hold_out",    int'(out),  8'hFE);

      // reset on the second SHIFT edge
      a = 8'h81; b = 8'd5; start = 1'b1;
      step();
      start = 1'b0;
      step();
      check("t5_mid_busy", int'(busy), 1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("t5_rst_out",  int'(out),  0);
      check("t5_rst_ovf",  int'(ovf),  0);
      check("t5_rst_busy", int'(busy), 0);
      check("t5_rst_done", int'(done), 0);
      step();
      check("t5_stay_idle", int'(busy), 0);
      run_op(8'h03, 8'd1, lat, bsy);
      check("t5_new_lat", lat,       2);
      check("t5_new_out", int'(out), 8'h06);
      check("t5_new_ovf", int'(ovf), 0);
      step();

      pats[0] = 8'h00; pats[1] = 8'h01; pats[2] = 8'h80; pats[3] = 8'hFF;
      for (int i = 0; i < 4; i++) begin
         for (int sh = 0; sh <= 10; sh++) begin
            ta = pats[i];
            if (sh >= 8) begin
               exp_out = 8'h00;
               exp_ovf = |ta;
               exp_lat = 1;
            end else begin
               exp_out = ta << sh;
               exp_ovf = (sh == 0) ? 1'b0 : |(ta >> (8 - sh));
               exp_lat = sh + 1;
            end
            run_op(ta, 8'(sh), lat, bsy);
            check($sformatf("sweep_lat_a%02h_b%0d", ta, sh), lat,       exp_lat);
            check($sformatf("sweep_out_a%02h_b%0d", ta, sh), int'(out), int'(exp_out));
            check($sformatf("sweep_ovf_a%02h_b%0d", ta, sh), int'(ovf), int'(exp_ovf));
            step();
         end
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
